// File: rtl/sw_data_processor.sv
// S/T sequence buffer and feeder for the PE-array controller, with ping-pong T banks for pass replay.
// Define SW_DP_ERR_CHK_EN to add the sticky o_err output.
//
// state | meaning
// IDLE  | waiting for host loads or start
// LOAD  | host loads in progress
// RUN   | heads valid, S/T streamed to the array, writebacks captured
// SWAP  | T pass ended, waiting for remaining writebacks before bank flip
// DONE  | run finished, one cycle before IDLE
module sw_data_processor #(
   parameter int VEF_W   = 16,
   parameter int S_DEPTH = 1024,
   parameter int T_DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load_s_vld,
   input  logic [1:0]       i_load_s,
   input  logic             i_load_t_vld,
   input  logic [1:0]       i_load_t,
   input  logic             i_start,
   output logic             o_busy,
   output logic             o_data_valid,
   input  logic             i_update_s_w,
   output logic [1:0]       o_s,
   output logic             o_s_last,
   input  logic             i_update_t_w,
   output logic [1:0]       o_t,
   output logic [VEF_W-1:0] o_v,
   output logic [VEF_W-1:0] o_f,
   output logic             o_t_last,
   input  logic             i_wb_valid,
   input  logic [1:0]       i_wb_t,
   input  logic [VEF_W-1:0] i_wb_v,
   input  logic [VEF_W-1:0] i_wb_f
`ifdef SW_DP_ERR_CHK_EN
   ,output logic            o_err
`endif
);

   localparam int S_AW = $clog2(S_DEPTH);
   localparam int T_AW = $clog2(T_DEPTH);
   localparam int TE_W = 2 + 2*VEF_W;
   localparam logic [S_AW:0] S_FULL = (S_AW+1)'(S_DEPTH);
   localparam logic [T_AW:0] T_FULL = (T_AW+1)'(T_DEPTH);
   localparam logic [S_AW:0] S_ONE  = {{S_AW{1'b0}}, 1'b1};
   localparam logic [T_AW:0] T_ONE  = {{T_AW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_SWAP, ST_DONE} state_t;
   state_t state;

   logic [1:0]      s_mem   [S_DEPTH];
   logic [TE_W-1:0] t_bank0 [T_DEPTH];
   logic [TE_W-1:0] t_bank1 [T_DEPTH];

   logic [S_AW:0]   s_len;
   logic [T_AW:0]   t_len, wb_cnt;
   logic [S_AW-1:0] s_ptr, s_ptr_inc;
   logic [T_AW-1:0] t_ptr, t_ptr_inc;
   logic            rd_bank, s_done;

   logic load_phase, any_load, s_load_ok, t_load_ok, start_ok;
   logic s_cons, t_cons, s_at_tail, t_at_tail, s_adv, s_tail_hit;
   logic wb_phase, wb_ok, swap_exit;
   logic [TE_W-1:0] wb_entry, t_rd_nxt, t_rd_swap;

   assign load_phase = (state == ST_IDLE) || (state == ST_LOAD);
   assign any_load   = load_phase && (i_load_s_vld || i_load_t_vld);
   assign s_load_ok  = load_phase && i_load_s_vld && (s_len != S_FULL);
   assign t_load_ok  = load_phase && i_load_t_vld && (t_len != T_FULL);
   // a load in the same cycle as start wins; the start is dropped
   assign start_ok   = load_phase && i_start && !any_load &&
                       (s_len != '0) && (t_len != '0);

   assign s_cons     = (state == ST_RUN) && o_data_valid && i_update_s_w;
   assign t_cons     = (state == ST_RUN) && o_data_valid && i_update_t_w;
   assign s_at_tail  = ({1'b0, s_ptr} == (s_len - 1'b1));
   assign t_at_tail  = ({1'b0, t_ptr} == (t_len - 1'b1));
   assign s_adv      = s_cons && !s_at_tail;
   assign s_tail_hit = s_cons && s_at_tail;
   assign s_ptr_inc  = s_ptr + 1'b1;
   assign t_ptr_inc  = t_ptr + 1'b1;

   assign wb_phase   = (state == ST_RUN) || (state == ST_SWAP);
   assign wb_ok      = wb_phase && i_wb_valid && (wb_cnt != t_len);
   assign swap_exit  = (state == ST_SWAP) && (wb_cnt == t_len);
   assign wb_entry   = {i_wb_t, i_wb_v, i_wb_f};

   assign t_rd_nxt   = rd_bank ? t_bank1[t_ptr_inc] : t_bank0[t_ptr_inc];
   assign t_rd_swap  = rd_bank ? t_bank0[0] : t_bank1[0];

   // storage has no reset; contents are undefined after rst
   always_ff @(posedge clk) begin
      if (s_load_ok)
         s_mem[s_len[S_AW-1:0]] <= i_load_s;
      if (t_load_ok)
         t_bank0[t_len[T_AW-1:0]] <= {i_load_t, {(2*VEF_W){1'b0}}};
      if (wb_ok) begin
         if (rd_bank)
            t_bank0[wb_cnt[T_AW-1:0]] <= wb_entry;
         else
            t_bank1[wb_cnt[T_AW-1:0]] <= wb_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         s_len        <= '0;
         t_len        <= '0;
         wb_cnt       <= '0;
         s_ptr        <= '0;
         t_ptr        <= '0;
         rd_bank      <= 1'b0;
         s_done       <= 1'b0;
         o_busy       <= 1'b0;
         o_data_valid <= 1'b0;
         o_s          <= '0;
         o_s_last     <= 1'b0;
         o_t          <= '0;
         o_v          <= '0;
         o_f          <= '0;
         o_t_last     <= 1'b0;
      end else begin
         if (s_load_ok) s_len  <= s_len + 1'b1;
         if (t_load_ok) t_len  <= t_len + 1'b1;
         if (wb_ok)     wb_cnt <= wb_cnt + 1'b1;
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (any_load) begin
                  state <= ST_LOAD;
               end else if (start_ok) begin
                  state               <= ST_RUN;
                  o_busy              <= 1'b1;
                  o_data_valid        <= 1'b1;
                  rd_bank             <= 1'b0;
                  s_ptr               <= '0;
                  t_ptr               <= '0;
                  wb_cnt              <= '0;
                  s_done              <= 1'b0;
                  o_s                 <= s_mem[0];
                  o_s_last            <= (s_len == S_ONE);
                  {o_t, o_v, o_f}     <= t_bank0[0];
                  o_t_last            <= (t_len == T_ONE);
               end
            end
            ST_RUN: begin
               if (s_adv) begin
                  s_ptr    <= s_ptr_inc;
                  o_s      <= s_mem[s_ptr_inc];
                  o_s_last <= ({1'b0, s_ptr_inc} == (s_len - 1'b1));
               end
               if (s_tail_hit) s_done <= 1'b1;
               if (t_cons) begin
                  if (t_at_tail) begin
                     o_data_valid <= 1'b0;
                     state        <= (s_done || s_tail_hit) ? ST_DONE : ST_SWAP;
                  end else begin
                     t_ptr           <= t_ptr_inc;
                     {o_t, o_v, o_f} <= t_rd_nxt;
                     o_t_last        <= ({1'b0, t_ptr_inc} == (t_len - 1'b1));
                  end
               end
            end
            ST_SWAP: begin
               if (swap_exit) begin
                  state           <= ST_RUN;
                  rd_bank         <= ~rd_bank;
                  wb_cnt          <= '0;
                  t_ptr           <= '0;
                  o_data_valid    <= 1'b1;
                  {o_t, o_v, o_f} <= t_rd_swap;
                  o_t_last        <= (t_len == T_ONE);
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SW_DP_ERR_CHK_EN
   localparam logic [T_AW+2:0] WD_LOAD = (T_AW+3)'(4*T_DEPTH);
   logic [T_AW+2:0] wd_cnt;
   logic load_drop, wb_drop, cons_bad, wd_trip;

   assign load_drop = load_phase && ((i_load_s_vld && (s_len == S_FULL)) ||
                                     (i_load_t_vld && (t_len == T_FULL)));
   assign wb_drop   = wb_phase && i_wb_valid && (wb_cnt == t_len);
   assign cons_bad  = (i_update_s_w || i_update_t_w) && !o_data_valid;
   assign wd_trip   = (state == ST_SWAP) && (wd_cnt == '0);

   // watchdog down-counter reloads whenever we are outside SWAP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_err  <= 1'b0;
         wd_cnt <= WD_LOAD;
      end else begin
         if (start_ok)
            o_err <= 1'b0;
         else if (load_drop || wb_drop || cons_bad || wd_trip)
            o_err <= 1'b1;
         if (state != ST_SWAP)
            wd_cnt <= WD_LOAD;
         else if (wd_cnt != '0)
            wd_cnt <= wd_cnt - 1'b1;
      end
   end
`endif

endmodule
